fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter and instruction-memory address width.
REQ-002 SHALL have parameter START_PC, default 0, PC loaded on start.
REQ-003 SHALL have ports clk in 1 (system clock) and rst_n in 1 (reset); one clock, reset synchronous active-low.
REQ-004 SHALL have port start in 1, a one-cycle pulse that begins fetching.
REQ-005 SHALL have ports imem_rd out 1 (read strobe) and imem_addr out PC_W (address).
REQ-006 SHALL have port imem_data in 9, valid exactly one cycle after imem_rd.
REQ-007 SHALL have ports br_taken in 1 (redirect from ALU stage) and br_target in PC_W (new PC).
REQ-008 SHALL have ports dec_valid out 1 (decoded instruction present) and dec_ready in 1 (ALU stage accepts).
REQ-009 SHALL have ports dec_op out 5 (canonical ALU opcode), dec_reg out 4 (register field), dec_imm out 8 (sign-extended immediate/offset) and dec_pc out PC_W (PC of the instruction).
REQ-010 SHALL have ports halted out 1 and illegal out 1.

Function
REQ-011 SHALL implement states IDLE, FETCH, WAIT, ISSUE, HALT, TRAP.
REQ-012 IDLE: on start, pc=START_PC and next state FETCH; all other inputs ignored.
REQ-013 FETCH: imem_rd=1 and imem_addr=pc for exactly one cycle, then WAIT.
REQ-014 WAIT: register decoded imem_data into the outputs, dec_pc=pc, pc=pc+1 modulo 2^PC_W, dec_valid=1, then ISSUE.
REQ-015 ISSUE: outputs held stable while dec_valid&&!dec_ready; on dec_valid&&dec_ready, dec_valid=0 next cycle and next state FETCH.
REQ-016 Decode, instr[8]=0: dec_op=instr[8:4], dec_reg=instr[3:0], dec_imm=0.
REQ-017 Decode, instr[8]=1 (ADDI/BNE/BEZ/MV): dec_op={instr[8:6],2'b00}, dec_reg={2'b00,instr[5:4]}, dec_imm=sign-extended instr[3:0].
REQ-018 Opcode 5'b00110 is HALT: in WAIT it is not issued, dec_valid stays 0, next state HALT; HALT holds halted=1 until reset.
REQ-019 br_taken in any of FETCH/WAIT/ISSUE: pc=br_target, dec_valid=0 next cycle, in-flight imem_data discarded, next state FETCH.
REQ-020 br_taken has priority over a simultaneous handshake or HALT decode; the squashed instruction counts as not accepted.
REQ-021 br_taken in IDLE, HALT or TRAP SHALL be ignored.
REQ-022 Throughput: at most one instruction per 3 cycles; latency from start to first dec_valid is 3 cycles.

Reset
REQ-023 On rst_n=0 at a clock edge: state=IDLE, pc=START_PC, dec_valid=0, dec_op/dec_reg/dec_imm/dec_pc=0, imem_rd=0, imem_addr=0, halted=0, illegal=0.
REQ-024 Reset mid-operation SHALL drop any pending or presented instruction with no further handshake.

Configuration
REQ-025 Macro FETCH_DECODE_ILLEGAL_TRAP_EN: when defined, opcodes 5'b00100 and 5'b00101 decoded in WAIT SHALL not issue, set illegal=1, and enter TRAP, held until reset.
REQ-026 When undefined, those opcodes SHALL issue as dec_op=ADD with dec_reg=0, dec_imm=0, and illegal SHALL be tied 0.

Structure
REQ-027 The state enum, the decoded-instruction struct (op, reg, imm) and the HALT opcode constant SHALL live in the shared definitions package beside the ALU opcodes.
REQ-028 The combinational field decode SHALL be one sub-module, instr_decoder; the FSM, PC and output registers stay in fetch_decode.

Verification
REQ-029 Reset, start, imem holds 9'b000000011 at addr 0, dec_ready=1 -> cycle 3: dec_valid=1, dec_op=ADD, dec_reg=3, dec_pc=0.
REQ-030 ADDI word 9'b100011110 -> dec_op=5'b10000, dec_reg=1, dec_imm=8'hFE; dec_ready=0 for 5 cycles -> outputs stable and no imem_rd.
REQ-031 br_taken=1 with br_target=0x040 while in ISSUE with dec_ready=1 -> instruction squashed, next imem_addr=0x040.
REQ-032 pc=0x3FF fetch -> following imem_addr=0x000.
REQ-033 HALT word 9'b001100000 -> dec_valid stays 0, halted=1; start and br_taken pulses have no effect.
REQ-034 Word 9'b001000000 -> with macro: illegal=1, TRAP; without: issued as ADD, reg 0.

Source files
------------

// File: rtl/fetch_decode_pkg.sv
// Shared definitions for fetch_decode: FSM states, decoded-instruction struct, ALU opcodes.
package fetch_decode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT,
    ST_TRAP
  } state_t;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rg;
    logic [7:0] imm;
  } dec_t;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b10000;
  localparam logic [4:0] OP_BNE   = 5'b10100;
  localparam logic [4:0] OP_BEZ   = 5'b11000;
  localparam logic [4:0] OP_MV    = 5'b11100;
  localparam logic [4:0] OP_HALT  = 5'b00110;
  localparam logic [4:0] OP_ILL_A = 5'b00100;
  localparam logic [4:0] OP_ILL_B = 5'b00101;

endpackage

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational field decode of a 9-bit instruction word into op/reg/imm.
// FETCH_DECODE_ILLEGAL_TRAP_EN: flag opcodes 00100/00101 instead of remapping them to ADD.
module instr_decoder
  import fetch_decode_pkg::*;
(
  input  logic [8:0] i_instr,
  output dec_t       o_dec,
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
  output logic       o_illegal,
`endif
  output logic       o_halt
);

  always_comb begin
    o_dec  = '0;
    o_halt = 1'b0;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    o_illegal = 1'b0;
`endif
    if (i_instr[8]) begin
      // Immediate forms carry only a 2-bit register and a signed 4-bit offset.
      case (i_instr[7:6])
        2'b00:   o_dec.op = OP_ADDI;
        2'b01:   o_dec.op = OP_BNE;
        2'b10:   o_dec.op = OP_BEZ;
        default: o_dec.op = OP_MV;
      endcase
      o_dec.rg  = {2'b00, i_instr[5:4]};
      o_dec.imm = {{4{i_instr[3]}}, i_instr[3:0]};
    end else begin
      o_dec.op = i_instr[8:4];
      o_dec.rg = i_instr[3:0];
      o_halt   = (i_instr[8:4] == OP_HALT);
      if (i_instr[8:4] == OP_ILL_A || i_instr[8:4] == OP_ILL_B) begin
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
        o_illegal = 1'b1;
`else
        o_dec.op = OP_ADD;
        o_dec.rg = 4'd0;
`endif
      end
    end
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: one instruction per 3 cycles, registered decode outputs, branch redirect.
// FETCH_DECODE_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state with illegal=1.
module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [8:0]      imem_data,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [4:0]      dec_op,
  output logic [3:0]      dec_reg,
  output logic [7:0]      dec_imm,
  output logic [PC_W-1:0] dec_pc,
  output logic            halted,
  output logic            illegal
);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_imem_rd;
  logic [PC_W-1:0] r_imem_addr;
  logic            r_dec_valid;
  dec_t            r_dec;
  logic [PC_W-1:0] r_dec_pc;
  logic            r_halted;
  dec_t            w_dec;
  logic            w_halt;
  logic            w_redirect;

`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
  logic            w_illegal;
  logic            r_illegal;

  instr_decoder u_dec (
    .i_instr   (imem_data),
    .o_dec     (w_dec),
    .o_illegal (w_illegal),
    .o_halt    (w_halt)
  );
  assign illegal = r_illegal;
`else
  instr_decoder u_dec (
    .i_instr (imem_data),
    .o_dec   (w_dec),
    .o_halt  (w_halt)
  );
  assign illegal = 1'b0;
`endif

  // Redirect only while actively fetching; IDLE/HALT/TRAP ignore it.
  assign w_redirect = br_taken &&
                      (r_state == ST_FETCH || r_state == ST_WAIT || r_state == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= START_PC;
      r_imem_rd   <= 1'b0;
      r_imem_addr <= '0;
      r_dec_valid <= 1'b0;
      r_dec       <= '0;
      r_dec_pc    <= '0;
      r_halted    <= 1'b0;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
      r_illegal   <= 1'b0;
`endif
    end else if (w_redirect) begin
      r_pc        <= br_target;
      r_imem_rd   <= 1'b1;
      r_imem_addr <= br_target;
      r_dec_valid <= 1'b0;
      r_state     <= ST_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: if (start) begin
          r_pc        <= START_PC;
          r_imem_rd   <= 1'b1;
          r_imem_addr <= START_PC;
          r_state     <= ST_FETCH;
        end
        ST_FETCH: begin
          r_imem_rd <= 1'b0;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
          end else if (w_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= ST_TRAP;
`endif
          end else begin
            r_dec       <= w_dec;
            r_dec_pc    <= r_pc;
            r_pc        <= r_pc + 1'b1;
            r_dec_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: if (dec_ready) begin
          r_dec_valid <= 1'b0;
          r_imem_rd   <= 1'b1;
          r_imem_addr <= r_pc;
          r_state     <= ST_FETCH;
        end
        default: ;
      endcase
    end
  end

  assign imem_rd   = r_imem_rd;
  assign imem_addr = r_imem_addr;
  assign dec_valid = r_dec_valid;
  assign dec_op    = r_dec.op;
  assign dec_reg   = r_dec.rg;
  assign dec_imm   = r_dec.imm;
  assign dec_pc    = r_dec_pc;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed and randomized checks of fetch_decode against an instruction-level reference model.
module tb_fetch_decode;
  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            imem_rd;
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_data = '0;
  logic            br_taken = 1'b0;
  logic [PC_W-1:0] br_target = '0;
  logic            dec_valid;
  logic            dec_ready = 1'b0;
  logic [4:0]      dec_op;
  logic [3:0]      dec_reg;
  logic [7:0]      dec_imm;
  logic [PC_W-1:0] dec_pc;
  logic            halted;
  logic            illegal;

  int errors = 0;
  int checks = 0;

  logic [8:0]      mem [0:1023];
  logic            rd_q = 1'b0;
  logic [PC_W-1:0] addr_q = '0;

  fetch_decode #(.PC_W(PC_W), .START_PC(10'h000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
    .br_taken(br_taken), .br_target(br_target),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op(dec_op), .dec_reg(dec_reg), .dec_imm(dec_imm), .dec_pc(dec_pc),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Memory returns the word one cycle after the read strobe, junk otherwise.
  always @(negedge clk) begin
    imem_data = rd_q ? mem[addr_q] : 9'($urandom);
    rd_q   = imem_rd;
    addr_q = imem_addr;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-format rules: {op, reg, imm}.
  function automatic logic [16:0] ref_dec(input logic [8:0] w);
    logic [4:0] op;
    logic [3:0] rg;
    logic [7:0] imm;
    if (w[8]) begin
      op  = {w[8:6], 2'b00};
      rg  = {2'b00, w[5:4]};
      imm = {{4{w[3]}}, w[3:0]};
    end else begin
      op  = w[8:4];
      rg  = w[3:0];
      imm = 8'h00;
      if (op == 5'b00100 || op == 5'b00101) begin
        op = 5'b00000;
        rg = 4'd0;
      end
    end
    return {op, rg, imm};
  endfunction

  function automatic logic [8:0] legal_word();
    logic [8:0] w;
    do w = 9'($urandom);
    while (!w[8] && (w[7:4] == 4'b0110 || w[7:4] == 4'b0100 || w[7:4] == 4'b0101));
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; br_taken = 1'b0; dec_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [PC_W-1:0] exp_pc;
    logic [16:0]     exp_f;
    int              gap;
    int              accepted;
    bit              presented;
    int              r;

    for (int i = 0; i < 1024; i++) mem[i] = legal_word();

    // Reset values
    repeat (3) tick();
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_imem_rd",   32'(imem_rd),   32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_halted",    32'(halted),    32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    check("rst_fields",    32'({dec_op, dec_reg, dec_imm}), 32'd0);
    check("rst_dec_pc",    32'(dec_pc),    32'd0);
    rst_n = 1'b1;
    tick();

    // First instruction: 3-cycle start latency
    mem[0] = 9'b000000011;
    mem[1] = 9'b100011110;
    mem[10'h040] = 9'b010100101;
    mem[10'h3FF] = 9'b000010001;
    dec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c1_imem_rd",   32'(imem_rd),   32'd1);
    check("c1_imem_addr", 32'(imem_addr), 32'd0);
    tick();
    check("c2_imem_rd",   32'(imem_rd),   32'd0);
    check("c2_dec_valid", 32'(dec_valid), 32'd0);
    tick();
    check("c3_dec_valid", 32'(dec_valid), 32'd1);
    check("c3_dec_op",    32'(dec_op),    32'd0);
    check("c3_dec_reg",   32'(dec_reg),   32'd3);
    check("c3_dec_imm",   32'(dec_imm),   32'd0);
    check("c3_dec_pc",    32'(dec_pc),    32'd0);
    tick();
    check("c4_dec_valid", 32'(dec_valid), 32'd0);
    check("c4_imem_addr", 32'(imem_addr), 32'd1);
    dec_ready = 1'b0;
    tick();
    tick();

    // ADDI held under backpressure
    for (int i = 0; i < 5; i++) begin
      check("addi_valid",   32'(dec_valid), 32'd1);
      check("addi_op",      32'(dec_op),    32'h10);
      check("addi_reg",     32'(dec_reg),   32'd1);
      check("addi_imm",     32'(dec_imm),   32'hFE);
      check("addi_pc",      32'(dec_pc),    32'd1);
      check("addi_no_rd",   32'(imem_rd),   32'd0);
      tick();
    end

    // Branch beats a simultaneous handshake
    dec_ready = 1'b1; br_taken = 1'b1; br_target = 10'h040;
    tick();
    br_taken = 1'b0;
    check("br_squash_valid", 32'(dec_valid), 32'd0);
    check("br_imem_rd",      32'(imem_rd),   32'd1);
    check("br_imem_addr",    32'(imem_addr), 32'h040);
    tick();
    tick();
    check("br_tgt_valid", 32'(dec_valid), 32'd1);
    check("br_tgt_pc",    32'(dec_pc),    32'h040);
    check("br_tgt_op",    32'(dec_op),    32'h0A);
    check("br_tgt_reg",   32'(dec_reg),   32'd5);

    // PC wrap at 0x3FF
    br_taken = 1'b1; br_target = 10'h3FF;
    tick();
    br_taken = 1'b0;
    check("wrap_addr_3ff", 32'(imem_addr), 32'h3FF);
    tick();
    tick();
    check("wrap_pc_3ff",   32'(dec_pc),    32'h3FF);
    check("wrap_valid",    32'(dec_valid), 32'd1);
    tick();
    check("wrap_imem_rd",   32'(imem_rd),   32'd1);
    check("wrap_imem_addr", 32'(imem_addr), 32'h000);
    dec_ready = 1'b0;
    tick();
    tick();
    check("midrst_pre_valid", 32'(dec_valid), 32'd1);

    // Reset mid-operation drops the presented instruction
    rst_n = 1'b0;
    tick();
    check("midrst_valid",   32'(dec_valid), 32'd0);
    check("midrst_imem_rd", 32'(imem_rd),   32'd0);
    rst_n = 1'b1;
    tick();

    // Randomized stream with stalls and redirects against the reference model
    for (int i = 0; i < 1024; i++) mem[i] = legal_word();
    exp_pc = '0; gap = 0; accepted = 0; presented = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 4000 && accepted < 60; cyc++) begin
      gap++;
      br_taken = 1'b0;
      if (dec_valid) begin
        exp_f = ref_dec(mem[exp_pc]);
        if (!presented) begin
          check("rnd_latency", 32'(gap), 32'd3);
          presented = 1'b1;
        end
        check("rnd_fields", 32'({dec_op, dec_reg, dec_imm}), 32'(exp_f));
        check("rnd_pc",     32'(dec_pc),  32'(exp_pc));
        check("rnd_no_rd",  32'(imem_rd), 32'd0);
      end
      r = $urandom_range(0, 9);
      dec_ready = (r < 6);
      if (r == 9) begin
        br_taken  = 1'b1;
        br_target = PC_W'($urandom);
        exp_pc    = br_target;
        presented = 1'b0;
        gap       = 0;
      end else if (dec_valid && dec_ready) begin
        exp_pc    = exp_pc + 1'b1;
        presented = 1'b0;
        gap       = 0;
        accepted++;
      end
      tick();
    end
    br_taken = 1'b0;
    check("rnd_accepted",   32'(accepted), 32'd60);
    check("rnd_halted",     32'(halted),   32'd0);
    check("rnd_illegal",    32'(illegal),  32'd0);

    // HALT is never issued and is sticky
    do_reset();
    mem[0] = 9'b001100000;
    dec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("halt_no_valid", 32'(dec_valid), 32'd0);
      tick();
    end
    check("halt_halted", 32'(halted), 32'd1);
    start = 1'b1; br_taken = 1'b1; br_target = 10'h010;
    tick();
    start = 1'b0; br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("halt_hold",      32'(halted),    32'd1);
      check("halt_hold_rd",   32'(imem_rd),   32'd0);
      check("halt_hold_vld",  32'(dec_valid), 32'd0);
    end

    // Opcode 00100: trap when enabled, ADD r0 otherwise
    do_reset();
    mem[0] = 9'b001000000;
    dec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
`ifdef FETCH_DECODE_ILLEGAL_TRAP_EN
    check("ill_flag",  32'(illegal),   32'd1);
    check("ill_valid", 32'(dec_valid), 32'd0);
    br_taken = 1'b1; br_target = 10'h020;
    tick();
    br_taken = 1'b0;
    tick();
    check("ill_hold",    32'(illegal),   32'd1);
    check("ill_no_rd",   32'(imem_rd),   32'd0);
    check("ill_no_vld",  32'(dec_valid), 32'd0);
    check("ill_no_halt", 32'(halted),    32'd0);
`else
    check("ill_issue_valid", 32'(dec_valid), 32'd1);
    check("ill_issue_flds",  32'({dec_op, dec_reg, dec_imm}), 32'd0);
    check("ill_issue_flag",  32'(illegal),   32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
